// File: rtl/rf_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_port_arbiter_if
// Description : Bundle of request, response and rf_32 port signals shared
//               between rf_port_arbiter and its environment.
//               slave  - arbiter view (takes requests, drives rf_32 ports)
//               master - environment view (requesters + rf_32 model)
//   req_valid/req_ready/req_write [1:0]  per-requester handshake
//   req_addr_s/req_addr_t/req_waddr      2 packed ADDR_WIDTH slices
//   req_wdata                            2 packed DATA_WIDTH slices
//   resp_valid/resp_id/resp_ready/resp_a/resp_b  response channel
//   rf_read_addr_s/t, rf_write_*         to rf_32
//   rf_outA/rf_outB                      from rf_32
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [1:0]              req_valid;
   logic [1:0]              req_ready;
   logic [1:0]              req_write;
   logic [2*ADDR_WIDTH-1:0] req_addr_s;
   logic [2*ADDR_WIDTH-1:0] req_addr_t;
   logic [2*ADDR_WIDTH-1:0] req_waddr;
   logic [2*DATA_WIDTH-1:0] req_wdata;

   logic                    resp_valid;
   logic                    resp_id;
   logic [1:0]              resp_ready;
   logic [DATA_WIDTH-1:0]   resp_a;
   logic [DATA_WIDTH-1:0]   resp_b;

   logic [ADDR_WIDTH-1:0]   rf_read_addr_s;
   logic [ADDR_WIDTH-1:0]   rf_read_addr_t;
   logic [ADDR_WIDTH-1:0]   rf_write_addr;
   logic                    rf_write_enabled;
   logic [DATA_WIDTH-1:0]   rf_write_data;
   logic [DATA_WIDTH-1:0]   rf_outA;
   logic [DATA_WIDTH-1:0]   rf_outB;

   modport slave (
      input  req_valid, req_write, req_addr_s, req_addr_t, req_waddr, req_wdata,
      input  resp_ready, rf_outA, rf_outB,
      output req_ready, resp_valid, resp_id, resp_a, resp_b,
      output rf_read_addr_s, rf_read_addr_t, rf_write_addr, rf_write_enabled,
      output rf_write_data
   );

   modport master (
      output req_valid, req_write, req_addr_s, req_addr_t, req_waddr, req_wdata,
      output resp_ready, rf_outA, rf_outB,
      input  req_ready, resp_valid, resp_id, resp_a, resp_b,
      input  rf_read_addr_s, rf_read_addr_t, rf_write_addr, rf_write_enabled,
      input  rf_write_data
   );
endinterface
`default_nettype wire

// File: rtl/rf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_port_arbiter
// Description : Two-requester round-robin arbiter in front of rf_32.
//               One transaction at a time: IDLE (accept) -> ISSUE (rf_32
//               ports driven, read data captured / write committed on the
//               closing edge) -> RESP (held until owner's resp_ready).
// Ports       : clock - system clock, posedge active
//               reset - asynchronous, active-high
//               bus   - rf_port_arbiter_if.slave (requests, responses, rf_32)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input wire            clock,
   input wire            reset,
   rf_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t                state_q;
   logic                  last_grant_q;
   logic                  resp_valid_q;
   logic                  resp_id_q;
   logic [DATA_WIDTH-1:0] resp_a_q;
   logic [DATA_WIDTH-1:0] resp_b_q;
   logic [ADDR_WIDTH-1:0] rf_addr_s_q;
   logic [ADDR_WIDTH-1:0] rf_addr_t_q;
   logic [ADDR_WIDTH-1:0] rf_waddr_q;
   logic [DATA_WIDTH-1:0] rf_wdata_q;
   logic                  rf_we_q;

   // Grant selection: a lone requester wins outright; on contention the
   // requester that did not win last time gets the port.
   logic                  w_grant_id;
   logic                  w_accept;
   logic                  w_sel_write;
   logic [ADDR_WIDTH-1:0] w_sel_addr_s;
   logic [ADDR_WIDTH-1:0] w_sel_addr_t;
   logic [ADDR_WIDTH-1:0] w_sel_waddr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;

   assign w_grant_id   = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
   // Reset gates the accept so req_ready is low for the whole reset window.
   assign w_accept     = (state_q == ST_IDLE) && (|bus.req_valid) && !reset;

   assign w_sel_write  = w_grant_id ? bus.req_write[1] : bus.req_write[0];
   assign w_sel_addr_s = w_grant_id ? bus.req_addr_s[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : bus.req_addr_s[ADDR_WIDTH-1:0];
   assign w_sel_addr_t = w_grant_id ? bus.req_addr_t[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : bus.req_addr_t[ADDR_WIDTH-1:0];
   assign w_sel_waddr  = w_grant_id ? bus.req_waddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                    : bus.req_waddr[ADDR_WIDTH-1:0];
   assign w_sel_wdata  = w_grant_id ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                    : bus.req_wdata[DATA_WIDTH-1:0];

   assign bus.req_ready = !w_accept ? 2'b00 : (w_grant_id ? 2'b10 : 2'b01);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_a_q     <= '0;
         resp_b_q     <= '0;
         rf_addr_s_q  <= '0;
         rf_addr_t_q  <= '0;
         rf_waddr_q   <= '0;
         rf_wdata_q   <= '0;
         rf_we_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_accept) begin
                  last_grant_q <= w_grant_id;
                  resp_id_q    <= w_grant_id;
                  rf_addr_s_q  <= w_sel_addr_s;
                  rf_addr_t_q  <= w_sel_addr_t;
                  rf_waddr_q   <= w_sel_waddr;
                  rf_wdata_q   <= w_sel_wdata;
                  rf_we_q      <= w_sel_write;
                  state_q      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // rf_we_q is high in ISSUE exactly when this is a write, so
               // it doubles as the transaction-type flag.
               resp_a_q     <= rf_we_q ? '0 : bus.rf_outA;
               resp_b_q     <= rf_we_q ? '0 : bus.rf_outB;
               resp_valid_q <= 1'b1;
               rf_we_q      <= 1'b0;
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.resp_ready[resp_id_q]) begin
                  resp_valid_q <= 1'b0;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.resp_valid       = resp_valid_q;
   assign bus.resp_id          = resp_id_q;
   assign bus.resp_a           = resp_a_q;
   assign bus.resp_b           = resp_b_q;
   assign bus.rf_read_addr_s   = rf_addr_s_q;
   assign bus.rf_read_addr_t   = rf_addr_t_q;
   assign bus.rf_write_addr    = rf_waddr_q;
   assign bus.rf_write_data    = rf_wdata_q;
   assign bus.rf_write_enabled = rf_we_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_port_arbiter
// Description : Self-checking bench for rf_port_arbiter with a behavioural
//               rf_32 model and a register/round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rf_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   rf_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   rf_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // rf_32 environment: write on posedge, read on negedge, r0 reads 0
   logic [DW-1:0] rf_mem [32];
   always @(posedge clock)
      if (bus.rf_write_enabled && bus.rf_write_addr != 0)
         rf_mem[bus.rf_write_addr] <= bus.rf_write_data;
   always @(negedge clock) begin
      bus.rf_outA <= (bus.rf_read_addr_s == 0) ? '0 : rf_mem[bus.rf_read_addr_s];
      bus.rf_outB <= (bus.rf_read_addr_t == 0) ? '0 : rf_mem[bus.rf_read_addr_t];
   end

   // Monitors (sampled on negedge)
   typedef struct {
      bit          id;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int          cyc;
   } resp_t;
   int      cyc = 0;
   int      hs_id_q [$];
   int      hs_cyc_q [$];
   resp_t   resp_q [$];
   int      we_cycles = 0;
   logic [AW-1:0] we_addr;
   logic [DW-1:0] we_data;

   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin
      if (!reset) begin
         if (|(bus.req_valid & bus.req_ready)) begin
            hs_id_q.push_back(int'(bus.req_ready[1]));
            hs_cyc_q.push_back(cyc);
         end
         if (bus.resp_valid && bus.resp_ready[bus.resp_id]) begin
            resp_t r;
            r.id = bus.resp_id; r.a = bus.resp_a; r.b = bus.resp_b; r.cyc = cyc;
            resp_q.push_back(r);
         end
         if (bus.rf_write_enabled) begin
            we_cycles++;
            we_addr = bus.rf_write_addr;
            we_data = bus.rf_write_data;
         end
      end
   end

   // Reference model
   logic [DW-1:0] model_mem [32];
   bit            model_last = 1'b1;
   int            n_vec = 0;
   int            n_err = 0;

   function automatic bit pick_winner(input logic [1:0] v);
      return (v == 2'b11) ? ~model_last : v[1];
   endfunction

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      return (a == 0) ? '0 : model_mem[a];
   endfunction

   task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (a != 0) model_mem[a] = d;
   endtask

   // Stimulus helpers (drive/wait only)
   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic set_req(input int id, input bit wr, input logic [AW-1:0] s,
                          input logic [AW-1:0] t, input logic [AW-1:0] w,
                          input logic [DW-1:0] d);
      bus.req_write[id]           = wr;
      bus.req_addr_s[id*AW +: AW] = s;
      bus.req_addr_t[id*AW +: AW] = t;
      bus.req_waddr[id*AW +: AW]  = w;
      bus.req_wdata[id*DW +: DW]  = d;
      bus.req_valid[id]           = 1'b1;
   endtask

   task automatic clear_mon();
      hs_id_q.delete(); hs_cyc_q.delete(); resp_q.delete();
   endtask

   task automatic wait_hs(input int n, output bit to);
      to = 1'b1;
      for (int i = 0; i < 40 * n; i++) begin
         tick();
         if (hs_id_q.size() >= n) begin to = 1'b0; break; end
      end
   endtask

   task automatic wait_resp(input int n, output bit to);
      to = 1'b1;
      for (int i = 0; i < 40 * n; i++) begin
         if (resp_q.size() >= n) begin to = 1'b0; break; end
         tick();
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      bus.req_valid = 2'b11;
      #1;
      n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready got=%b exp=00", bus.req_ready); end
      n_vec++; if (bus.resp_valid !== 1'b0 || bus.resp_id !== 1'b0) begin n_err++; $display("FAIL rst_resp got v=%b id=%b exp 0/0", bus.resp_valid, bus.resp_id); end
      n_vec++; if (bus.resp_a !== '0 || bus.resp_b !== '0) begin n_err++; $display("FAIL rst_resp_data got a=%h b=%h exp 0", bus.resp_a, bus.resp_b); end
      n_vec++; if (bus.rf_write_enabled !== 1'b0 || bus.rf_read_addr_s !== '0 || bus.rf_read_addr_t !== '0 || bus.rf_write_addr !== '0 || bus.rf_write_data !== '0) begin
         n_err++; $display("FAIL rst_rf_outputs got we=%b s=%0d t=%0d w=%0d d=%h exp all 0", bus.rf_write_enabled, bus.rf_read_addr_s, bus.rf_read_addr_t, bus.rf_write_addr, bus.rf_write_data);
      end
      bus.req_valid = 2'b00;
      @(posedge clock); #1;
      reset = 1'b0;
      model_last = 1'b1;
   endtask

   task automatic test_write_ack();
      bit to; int we0;
      clear_mon(); we0 = we_cycles;
      bus.resp_ready = 2'b11;
      set_req(0, 1'b1, 5'd1, 5'd2, 5'd5, 32'hDEADBEEF);
      wait_hs(1, to);
      bus.req_valid = 2'b00;
      n_vec++; if (to) begin n_err++; $display("FAIL wr_hs timeout"); return; end
      n_vec++; if (hs_id_q[0] != 0) begin n_err++; $display("FAIL wr_grant got=%0d exp=0", hs_id_q[0]); end
      wait_resp(1, to);
      n_vec++; if (to) begin n_err++; $display("FAIL wr_resp timeout"); return; end
      n_vec++; if (resp_q[0].id !== 1'b0 || resp_q[0].a !== '0 || resp_q[0].b !== '0) begin
         n_err++; $display("FAIL wr_ack got id=%0d a=%h b=%h exp id=0 a=0 b=0", resp_q[0].id, resp_q[0].a, resp_q[0].b);
      end
      n_vec++; if (resp_q[0].cyc - hs_cyc_q[0] != 2) begin n_err++; $display("FAIL wr_latency got=%0d exp=2", resp_q[0].cyc - hs_cyc_q[0]); end
      n_vec++; if (we_cycles - we0 != 1 || we_addr !== 5'd5 || we_data !== 32'hDEADBEEF) begin
         n_err++; $display("FAIL wr_pulse got cycles=%0d addr=%0d data=%h exp 1/5/deadbeef", we_cycles - we0, we_addr, we_data);
      end
      model_write(5'd5, 32'hDEADBEEF); model_last = 1'b0;
   endtask

   task automatic test_raw_read();
      bit to;
      clear_mon();
      set_req(1, 1'b0, 5'd5, 5'd0, 5'd9, 32'h0);
      wait_hs(1, to);
      bus.req_valid = 2'b00;
      n_vec++; if (to) begin n_err++; $display("FAIL raw_hs timeout"); return; end
      n_vec++; if (hs_id_q[0] != 1) begin n_err++; $display("FAIL raw_grant got=%0d exp=1", hs_id_q[0]); end
      wait_resp(1, to);
      n_vec++; if (to) begin n_err++; $display("FAIL raw_resp timeout"); return; end
      n_vec++; if (resp_q[0].id !== 1'b1 || resp_q[0].a !== model_read(5'd5) || resp_q[0].b !== 32'h0) begin
         n_err++; $display("FAIL raw_data got id=%0d a=%h b=%h exp id=1 a=%h b=0", resp_q[0].id, resp_q[0].a, resp_q[0].b, model_read(5'd5));
      end
      model_last = 1'b1;
   endtask

   task automatic test_round_robin();
      bit to; bit exp_id;
      clear_mon();
      bus.resp_ready = 2'b11;
      set_req(0, 1'b0, 5'd5, 5'd3, 5'd0, 32'h0);
      set_req(1, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0);
      wait_hs(4, to);
      bus.req_valid = 2'b00;
      n_vec++; if (to) begin n_err++; $display("FAIL rr_hs timeout"); return; end
      wait_resp(4, to);
      n_vec++; if (to) begin n_err++; $display("FAIL rr_resp timeout"); return; end
      for (int k = 0; k < 4; k++) begin
         exp_id = pick_winner(2'b11);
         n_vec++; if (hs_id_q[k] != int'(exp_id)) begin n_err++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", k, hs_id_q[k], exp_id); end
         if (k > 0) begin
            n_vec++; if (hs_cyc_q[k] - hs_cyc_q[k-1] != 3) begin n_err++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", k, hs_cyc_q[k] - hs_cyc_q[k-1]); end
         end
         n_vec++;
         if (exp_id == 1'b0) begin
            if (resp_q[k].id !== 1'b0 || resp_q[k].a !== model_read(5'd5) || resp_q[k].b !== model_read(5'd3)) begin
               n_err++; $display("FAIL rr_resp[%0d] got id=%0d a=%h b=%h exp id=0", k, resp_q[k].id, resp_q[k].a, resp_q[k].b);
            end
         end else begin
            if (resp_q[k].id !== 1'b1 || resp_q[k].a !== 32'h0 || resp_q[k].b !== model_read(5'd5)) begin
               n_err++; $display("FAIL rr_resp[%0d] got id=%0d a=%h b=%h exp id=1", k, resp_q[k].id, resp_q[k].a, resp_q[k].b);
            end
         end
         model_last = exp_id;
      end
   endtask

   task automatic test_r0();
      bit to;
      clear_mon();
      set_req(0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678);
      wait_hs(1, to); bus.req_valid = 2'b00;
      wait_resp(1, to);
      model_write(5'd0, 32'h12345678); model_last = 1'b0;
      set_req(0, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0);
      wait_hs(2, to); bus.req_valid = 2'b00;
      wait_resp(2, to);
      n_vec++; if (to) begin n_err++; $display("FAIL r0_resp timeout"); return; end
      n_vec++; if (resp_q[1].a !== 32'h0 || resp_q[1].b !== model_read(5'd5)) begin
         n_err++; $display("FAIL r0_read got a=%h b=%h exp a=0 b=%h", resp_q[1].a, resp_q[1].b, model_read(5'd5));
      end
   endtask

   task automatic test_backpressure();
      bit to;
      clear_mon();
      bus.resp_ready = 2'b00;
      set_req(0, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
      wait_hs(1, to); bus.req_valid = 2'b00;
      n_vec++; if (to) begin n_err++; $display("FAIL bp_hs timeout"); return; end
      model_last = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 10; i++) begin tick(); if (bus.resp_valid) begin to = 1'b0; break; end end
      n_vec++; if (to) begin n_err++; $display("FAIL bp_valid timeout"); return; end
      bus.req_valid = 2'b10;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++; if (bus.resp_valid !== 1'b1 || bus.resp_a !== model_read(5'd5) || bus.resp_id !== 1'b0) begin
            n_err++; $display("FAIL bp_hold[%0d] got v=%b a=%h id=%b exp v=1 a=%h id=0", i, bus.resp_valid, bus.resp_a, bus.resp_id, model_read(5'd5));
         end
         n_vec++; if (bus.req_ready !== 2'b00) begin n_err++; $display("FAIL bp_req_ready[%0d] got=%b exp=00", i, bus.req_ready); end
      end
      bus.resp_ready = 2'b10;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_vec++; if (bus.resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_other_ready[%0d] got v=%b exp=1", i, bus.resp_valid); end
      end
      bus.req_valid = 2'b00;
      bus.resp_ready = 2'b01;
      wait_resp(1, to);
      tick();
      n_vec++; if (to || bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_complete got timeout=%0d v=%b exp 0/0", to, bus.resp_valid); end
      bus.resp_ready = 2'b11;
   endtask

   task automatic test_reset_during_issue();
      bit to; logic [DW-1:0] old7;
      old7 = model_read(5'd7);
      clear_mon();
      bus.resp_ready = 2'b11;
      set_req(0, 1'b1, 5'd0, 5'd0, 5'd7, 32'hA5A5A5A5);
      wait_hs(1, to);
      bus.req_valid = 2'b00;
      n_vec++; if (to || bus.rf_write_enabled !== 1'b1) begin n_err++; $display("FAIL rsti_issue got timeout=%0d we=%b exp 0/1", to, bus.rf_write_enabled); end
      reset = 1'b1;
      #1;
      n_vec++; if (bus.rf_write_enabled !== 1'b0) begin n_err++; $display("FAIL rsti_we_drop got=%b exp=0", bus.rf_write_enabled); end
      tick();
      reset = 1'b0;
      model_last = 1'b1;
      clear_mon();
      repeat (4) tick();
      n_vec++; if (resp_q.size() != 0 || bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rsti_no_resp got n=%0d v=%b exp 0/0", resp_q.size(), bus.resp_valid); end
      set_req(0, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0);
      set_req(1, 1'b0, 5'd5, 5'd7, 5'd0, 32'h0);
      wait_hs(1, to);
      bus.req_valid = 2'b00;
      n_vec++; if (to) begin n_err++; $display("FAIL rsti_hs timeout"); return; end
      n_vec++; if (hs_id_q[0] != int'(pick_winner(2'b11))) begin n_err++; $display("FAIL rsti_grant got=%0d exp=%0d", hs_id_q[0], pick_winner(2'b11)); end
      model_last = pick_winner(2'b11);
      wait_resp(1, to);
      n_vec++; if (to) begin n_err++; $display("FAIL rsti_resp timeout"); return; end
      n_vec++; if (resp_q[0].id !== 1'b0 || resp_q[0].a !== old7 || resp_q[0].b !== model_read(5'd5)) begin
         n_err++; $display("FAIL rsti_r7 got id=%0d a=%h b=%h exp id=0 a=%h", resp_q[0].id, resp_q[0].a, resp_q[0].b, old7);
      end
   endtask

   task automatic test_random();
      bit to; bit win; logic [1:0] v;
      bit wr [2]; logic [AW-1:0] s [2], t [2], w [2]; logic [DW-1:0] d [2];
      logic [DW-1:0] ea, eb;
      for (int n = 0; n < 40; n++) begin
         clear_mon();
         v = 2'($urandom_range(1, 3));
         for (int r = 0; r < 2; r++) begin
            wr[r] = 1'($urandom_range(0, 1));
            s[r] = 5'($urandom_range(0, 7)); t[r] = 5'($urandom_range(0, 7));
            w[r] = 5'($urandom_range(0, 7)); d[r] = $urandom;
            if (v[r]) set_req(r, wr[r], s[r], t[r], w[r], d[r]);
         end
         bus.resp_ready = 2'b00;
         win = pick_winner(v);
         wait_hs(1, to);
         bus.req_valid = 2'b00;
         n_vec++; if (to) begin n_err++; $display("FAIL rnd_hs[%0d] timeout", n); return; end
         n_vec++; if (hs_id_q[0] != int'(win)) begin n_err++; $display("FAIL rnd_grant[%0d] got=%0d exp=%0d", n, hs_id_q[0], win); end
         model_last = win;
         ea = wr[win] ? '0 : model_read(s[win]);
         eb = wr[win] ? '0 : model_read(t[win]);
         if (wr[win]) model_write(w[win], d[win]);
         repeat ($urandom_range(0, 3)) tick();
         bus.resp_ready = ($urandom_range(0, 1) != 0) ? 2'b11 : (win ? 2'b10 : 2'b01);
         wait_resp(1, to);
         n_vec++; if (to) begin n_err++; $display("FAIL rnd_resp[%0d] timeout", n); return; end
         n_vec++; if (resp_q[0].id !== win || resp_q[0].a !== ea || resp_q[0].b !== eb) begin
            n_err++; $display("FAIL rnd_data[%0d] got id=%0d a=%h b=%h exp id=%0d a=%h b=%h", n, resp_q[0].id, resp_q[0].a, resp_q[0].b, win, ea, eb);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin rf_mem[i] = '0; model_mem[i] = '0; end
      bus.req_valid  = 2'b00; bus.req_write = 2'b00;
      bus.req_addr_s = '0; bus.req_addr_t = '0; bus.req_waddr = '0; bus.req_wdata = '0;
      bus.resp_ready = 2'b11;
      #2 reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      test_reset();
      test_write_ack();
      test_raw_read();
      test_round_robin();
      test_r0();
      test_backpressure();
      test_reset_during_issue();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit reached");
   end
endmodule
`default_nettype wire

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single-read-pair / single-write-port rf_32 register file.
- Typical requesters: pipeline decode/writeback (requester 0) and the debug/exception unit (requester 1).
- Accepts one transaction at a time (read of two registers, or write of one) and sequences the rf_32 port signals.
- Captures rf_32 read data (rf_32 registers read data on negedge) and returns it through a valid/ready response channel.

Parameters:
- DATA_WIDTH, 32, register width; matches rf_32 REG_SIZE.
- ADDR_WIDTH, 5, register index width; matches rf_32 INDEX_SIZE.

Ports:
- clock  in  1  single system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high.
- req_write  in  2  per-requester: 1 = write transaction, 0 = read transaction.
- req_addr_s  in  2*ADDR_WIDTH  read index s; requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_addr_t  in  2*ADDR_WIDTH  read index t; same packing.
- req_waddr  in  2*ADDR_WIDTH  write index; same packing.
- req_wdata  in  2*DATA_WIDTH  write data; same packing.
- resp_valid  out  1  response available.
- resp_id  out  1  requester that owns the response.
- resp_ready  in  2  per-requester response accept; only bit resp_id is honoured.
- resp_a  out  DATA_WIDTH  read data for addr_s; 0 for write acks.
- resp_b  out  DATA_WIDTH  read data for addr_t; 0 for write acks.
- rf_read_addr_s  out  ADDR_WIDTH  to rf_32 read_addr_s.
- rf_read_addr_t  out  ADDR_WIDTH  to rf_32 read_addr_t.
- rf_write_addr  out  ADDR_WIDTH  to rf_32 write_addr.
- rf_write_enabled  out  1  to rf_32 write_enabled.
- rf_write_data  out  DATA_WIDTH  to rf_32 write_data.
- rf_outA  in  DATA_WIDTH  from rf_32 outA.
- rf_outB  in  DATA_WIDTH  from rf_32 outB.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; last_grant = 1, so requester 0 wins the first contest.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_a = resp_b = 0.
  - All rf_* outputs = 0; rf_write_enabled deasserts the moment reset asserts.
  - An in-flight transaction is dropped; no response is produced for it.
- FSM states: IDLE, ISSUE, RESP. Each transaction occupies at least 3 cycles.
- IDLE:
  - req_ready is combinational from req_valid and last_grant, and is high only in IDLE.
  - Only one requester valid: that requester gets ready.
  - Both valid: grant goes to ~last_grant.
  - Neither valid: req_ready = 0.
  - On the handshake edge (valid & ready): latch the granted requester's fields, set last_grant = granted id, load the rf_* address/data registers, set rf_write_enabled = req_write[id], go to ISSUE.
- ISSUE (exactly 1 cycle):
  - rf_* outputs are stable for the whole cycle; rf_32 reads on the mid-cycle negedge.
  - At the ending posedge:
    - rf_32 commits the write if rf_write_enabled = 1.
    - The arbiter captures rf_outA/rf_outB into resp_a/resp_b for a read, or 0/0 for a write.
    - rf_write_enabled clears; go to RESP.
- RESP:
  - resp_valid = 1 and resp_id = latched id; resp_a, resp_b and resp_id stay stable while waiting.
  - On posedge with resp_ready[resp_id] = 1: resp_valid = 0, go to IDLE.
  - resp_ready of the other requester is ignored.
- Latency: request accepted at edge N; response visible in cycle N+2; minimum accept-to-accept spacing is 3 cycles when resp_ready is held high.
- rf address/data outputs hold their last values outside ISSUE; only rf_write_enabled qualifies them.
- Hazards: a write's commit edge precedes the next transaction's ISSUE, so a read-after-write, from either requester, returns the new value. No bypass logic.
- Write to index 0 is passed through unchanged; rf_32 ignores it. A later read of r0 returns 0.
- req_* inputs are sampled only on the handshake edge; changes at other times have no effect.
- Round-robin fairness: under continuous contention, grants alternate 0,1,0,1.

Test Plan:
- Reset, then requester 0 writes r5 = 0xDEADBEEF → rf_write_enabled high for exactly 1 cycle with addr 5; ack resp_id=0, resp_a=resp_b=0 at N+2.
- Requester 1 then reads s=5, t=0 → resp_id=1, resp_a=0xDEADBEEF, resp_b=0 (read-after-write, r0 hardwired).
- Both requesters valid continuously for 4 transactions, resp_ready=2'b11 → grant order 0,1,0,1; accepts spaced exactly 3 cycles.
- Write r0 = 0x12345678, then read s=0 → resp_a=0.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_a stable; req_ready=0 throughout; assert resp_ready[~resp_id] only → no completion.
- Assert reset during ISSUE of a write to r7 = 0xA5A5A5A5 → rf_write_enabled drops immediately, r7 unchanged when read after reset, no response, next grant goes to requester 0.
